// File: rtl/led_match_game_if.sv
// rtl/led_match_game_if.sv - player controls and display bus for the LED match game
interface led_match_game_if #(
    parameter int LED_W = 10
);
    logic                 enter;
    logic [LED_W/2-1:0]   sw_A;
    logic [LED_W/2-1:0]   sw_B;
    logic [LED_W-1:0]     led_out;
    logic [3:0]           seg_A;
    logic [3:0]           seg_B;
    logic [7:0]           rounds;
    logic [31:0]          flag;
    logic                 game_over;

    // Player/console side: drives buttons and switches, watches the displays
    modport master (
        output enter, sw_A, sw_B,
        input  led_out, seg_A, seg_B, rounds, flag, game_over
    );

    // Game controller side
    modport slave (
        input  enter, sw_A, sw_B,
        output led_out, seg_A, seg_B, rounds, flag, game_over
    );
endinterface

// File: rtl/led_match_game.sv
// rtl/led_match_game.sv - two-player LED memory/match round controller
module led_match_game #(
    parameter int          LED_W       = 10,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          SHOW_CYC    = 50000000,
    parameter int          TIMEOUT_CYC = 250000000,
    parameter int          RESULT_CYC  = 50000000,
    parameter int          LIVES       = 3
) (
    input  logic               clk,
    input  logic               rst,
    led_match_game_if.slave    bus
);
    localparam int HALF = LED_W / 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    localparam int MAX_CYC = max3(SHOW_CYC, TIMEOUT_CYC, RESULT_CYC);
    localparam int TW      = $clog2(MAX_CYC) + 1;

    localparam logic [31:0] GLYPH_PASS  = 32'hC2A3A3A1;
    localparam logic [31:0] GLYPH_FAIL  = 32'hC7C09286;
    localparam logic [31:0] GLYPH_BLANK = 32'hFFFFFFFF;
    localparam logic [15:0] LFSR_MASK   = 16'hB400;
    localparam logic [3:0]  LIVES4      = LIVES[3:0];

    localparam logic [TW-1:0] SHOW_LAST    = TW'(SHOW_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] RESULT_LAST  = TW'(RESULT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SHOW   = 3'd1,
        S_WAIT   = 3'd2,
        S_JUDGE  = 3'd3,
        S_RESULT = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    state_t            state_q;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              enter_q;
    logic [TW-1:0]     timer_q;
    logic [LED_W-1:0]  pattern_q;
    logic [LED_W-1:0]  led_q;
    logic [3:0]        seg_a_q, seg_b_q;
    logic [7:0]        rounds_q;
    logic [31:0]       flag_q;
    logic              game_over_q;
    logic              timeout_q;

    logic              ev;
    logic [LED_W-1:0]  pat_raw, pat_next;
    logic              ok_a, ok_b;
    logic [LED_W-1:0]  over_leds;

    assign ev = bus.enter & ~enter_q;

    // A zero pattern would show nothing, so it is replaced by a single lit LED
    assign pat_raw  = lfsr_q[LED_W-1:0];
    assign pat_next = (pat_raw == '0) ? LED_W'(1) : pat_raw;

    // A timeout judges both players wrong regardless of their switches
    assign ok_a = (bus.sw_A == pattern_q[LED_W-1:HALF]) && !timeout_q;
    assign ok_b = (bus.sw_B == pattern_q[HALF-1:0])     && !timeout_q;

    // Galois step, taps 16,14,13,11
    assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);

    // Game-over display lights the surviving player's half, or everything if both are out
    always_comb begin
        over_leds = '0;
        if (seg_a_q == 4'd0 && seg_b_q == 4'd0) begin
            over_leds = '1;
        end else if (seg_b_q == 4'd0) begin
            over_leds = {{HALF{1'b1}}, {HALF{1'b0}}};
        end else if (seg_a_q == 4'd0) begin
            over_leds = {{HALF{1'b0}}, {HALF{1'b1}}};
        end
    end

    // Free-running LFSR and enter edge detector; enter_q resets high so a held button is not a press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q  <= SEED;
            enter_q <= 1'b1;
        end else begin
            lfsr_q  <= lfsr_d;
            enter_q <= bus.enter;
        end
    end

    // Round FSM with registered display outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            pattern_q   <= '0;
            led_q       <= '0;
            seg_a_q     <= LIVES4;
            seg_b_q     <= LIVES4;
            rounds_q    <= 8'd0;
            flag_q      <= GLYPH_BLANK;
            game_over_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    flag_q <= GLYPH_BLANK;
                    led_q  <= '0;
                    if (ev) begin
                        pattern_q <= pat_next;
                        led_q     <= pat_next;
                        timer_q   <= '0;
                        state_q   <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (timer_q == SHOW_LAST) begin
                        led_q     <= '0;
                        timer_q   <= '0;
                        timeout_q <= 1'b0;
                        state_q   <= S_WAIT;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (ev) begin
                        timeout_q <= 1'b0;
                        state_q   <= S_JUDGE;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_JUDGE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_JUDGE: begin
                    if (!ok_a && seg_a_q != 4'd0) begin
                        seg_a_q <= seg_a_q - 1'b1;
                    end
                    if (!ok_b && seg_b_q != 4'd0) begin
                        seg_b_q <= seg_b_q - 1'b1;
                    end
                    flag_q <= (ok_a && ok_b) ? GLYPH_PASS : GLYPH_FAIL;
                    if (rounds_q != 8'hFF) begin
                        rounds_q <= rounds_q + 1'b1;
                    end
                    timer_q <= '0;
                    state_q <= S_RESULT;
                end
                S_RESULT: begin
                    if (timer_q == RESULT_LAST) begin
                        timer_q <= '0;
                        if (seg_a_q == 4'd0 || seg_b_q == 4'd0) begin
                            game_over_q <= 1'b1;
                            led_q       <= over_leds;
                            state_q     <= S_OVER;
                        end else begin
                            flag_q  <= GLYPH_BLANK;
                            led_q   <= '0;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_OVER: begin
                    if (ev) begin
                        seg_a_q     <= LIVES4;
                        seg_b_q     <= LIVES4;
                        rounds_q    <= 8'd0;
                        flag_q      <= GLYPH_BLANK;
                        led_q       <= '0;
                        game_over_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.led_out   = led_q;
    assign bus.seg_A     = seg_a_q;
    assign bus.seg_B     = seg_b_q;
    assign bus.rounds    = rounds_q;
    assign bus.flag      = flag_q;
    assign bus.game_over = game_over_q;
endmodule

// File: tb/tb_led_match_game.sv
// tb/tb_led_match_game.sv - randomized self-checking bench for led_match_game
module tb_led_match_game;
    localparam int          LED_W = 10;
    localparam int          LIVES = 2;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam logic [31:0] PASS_G  = 32'hC2A3A3A1;
    localparam logic [31:0] FAIL_G  = 32'hC7C09286;
    localparam logic [31:0] BLANK_G = 32'hFFFFFFFF;

    logic clk;
    logic rst;
    led_match_game_if #(.LED_W(LED_W)) bus ();

    led_match_game #(
        .LED_W(LED_W), .SEED(SEED), .SHOW_CYC(4), .TIMEOUT_CYC(8),
        .RESULT_CYC(3), .LIVES(LIVES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference LFSR: Galois, mask 16'hB400, steps every clock, SEED on reset
    logic [15:0] m_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    int m_lives_a;
    int m_lives_b;
    int m_rounds;
    logic [31:0] m_flag;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_led"}, 32'(bus.led_out), 32'd0);
        check({tag, "_flag"}, bus.flag, BLANK_G);
        check({tag, "_over"}, 32'(bus.game_over), 32'd0);
        check({tag, "_segA"}, 32'(bus.seg_A), 32'(m_lives_a));
        check({tag, "_segB"}, 32'(bus.seg_B), 32'(m_lives_b));
        check({tag, "_rounds"}, 32'(bus.rounds), 32'(m_rounds));
    endtask

    function automatic logic [LED_W-1:0] over_leds(input int la, input int lb);
        if (la == 0 && lb == 0) return 10'h3FF;
        if (la == 0)            return 10'h01F;
        if (lb == 0)            return 10'h3E0;
        return 10'h000;
    endfunction

    // mode: 0 both right, 1 A wrong B right, 2 timeout, 3 random; delay = WAIT cycles before press
    task automatic play(input int mode, input int delay);
        logic [LED_W-1:0] pat;
        logic ok_a, ok_b, to;
        pat = m_lfsr[LED_W-1:0];
        if (pat == '0) pat = 10'd1;
        bus.enter = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("show_led", 32'(bus.led_out), 32'(pat));
            bus.enter = (i < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        check("wait_led", 32'(bus.led_out), 32'd0);
        to = 1'b0;
        case (mode)
            0: begin ok_a = 1'b1; ok_b = 1'b1; end
            1: begin ok_a = 1'b0; ok_b = 1'b1; end
            2: begin ok_a = 1'b1; ok_b = 1'b1; to = 1'b1; end
            default: begin
                ok_a = 1'($urandom_range(0, 1));
                ok_b = 1'($urandom_range(0, 1));
                to   = ($urandom_range(0, 4) == 0);
            end
        endcase
        bus.sw_A = ok_a ? pat[9:5] : (pat[9:5] ^ 5'($urandom_range(1, 31)));
        bus.sw_B = ok_b ? pat[4:0] : (pat[4:0] ^ 5'($urandom_range(1, 31)));
        if (to) begin
            ok_a = 1'b0;
            ok_b = 1'b0;
            repeat (8) tick();
        end else begin
            repeat (delay) tick();
            bus.enter = 1'b1;
            tick();
            bus.enter = 1'b0;
        end
        check("judge_flag_latency", bus.flag, BLANK_G);
        check("judge_segA_latency", 32'(bus.seg_A), 32'(m_lives_a));
        tick();
        if (!ok_a && m_lives_a > 0) m_lives_a--;
        if (!ok_b && m_lives_b > 0) m_lives_b--;
        if (m_rounds < 255) m_rounds++;
        m_flag = (ok_a && ok_b) ? PASS_G : FAIL_G;
        check("result_segA", 32'(bus.seg_A), 32'(m_lives_a));
        check("result_segB", 32'(bus.seg_B), 32'(m_lives_b));
        check("result_rounds", 32'(bus.rounds), 32'(m_rounds));
        for (int i = 0; i < 3; i++) begin
            check("result_flag", bus.flag, m_flag);
            bus.enter = (i < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        if (m_lives_a == 0 || m_lives_b == 0) begin
            check("over_flag", 1'b1 ? bus.flag : 32'd0, m_flag);
            check("over_go", 32'(bus.game_over), 32'd1);
            check("over_led", 32'(bus.led_out), 32'(over_leds(m_lives_a, m_lives_b)));
        end else begin
            check_idle("next_idle");
        end
    endtask

    task automatic restart();
        repeat ($urandom_range(1, 3)) begin
            tick();
            check("over_hold", 32'(bus.game_over), 32'd1);
        end
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
        m_lives_a = LIVES;
        m_lives_b = LIVES;
        m_rounds  = 0;
        check_idle("restart");
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        m_lives_a = LIVES;
        m_lives_b = LIVES;
        m_rounds  = 0;
        m_flag    = BLANK_G;
        rst       = 1'b1;
        bus.enter = 1'b1;
        bus.sw_A  = '0;
        bus.sw_B  = '0;
        repeat (3) tick();
        check_idle("reset");
        rst = 1'b0;
        repeat (3) tick();
        check_idle("held_enter");
        bus.enter = 1'b0;
        tick();

        play(0, 2);
        play(1, 7);

        // Reset in the middle of SHOW
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        m_lives_a = LIVES;
        m_lives_b = LIVES;
        m_rounds  = 0;
        check_idle("rst_mid_show");
        tick();
        rst = 1'b0;
        tick();
        check_idle("after_rst");

        play(1, 0);
        play(2, 0);
        if (bus.game_over) restart();

        for (int r = 0; r < 30; r++) begin
            play(3, $urandom_range(0, 7));
            if (m_lives_a == 0 || m_lives_b == 0) restart();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
